regfile_writeback: RTL

- Write-side initiator for the register file write port (WEN/wsel/wdat).
- Merges two result producers into the single write port and drives it from registers:
  - ALU path: single-cycle results.
  - Load path: memory results, buffered in a small FIFO.
- Keeps a 32-bit pending-write scoreboard so decode can stall on read-after-write hazards.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/regfile_writeback_if.sv | 39 +++
 rtl/regfile_writeback_fifo.sv | 47 ++++
 rtl/regfile_writeback.sv | 85 ++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths and the write-back entry format.
package cpu_types_pkg;
    localparam int WORD_W        = 32;
    localparam int WB_FIFO_DEPTH = 4;
    localparam int WB_STARVE_MAX = 3;

    typedef logic [4:0]        regbits_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        regbits_t wsel;
        word_t    wdat;
    } wb_entry_t;

    function automatic logic [31:0] reg_bit(regbits_t r);
        reg_bit = 32'd1 << r;
    endfunction
endpackage

// File: rtl/regfile_writeback_if.sv
// Producer/decode side of the write-back stage and the register file write port it drives.
interface regfile_writeback_if
    import cpu_types_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
);
    logic                        alu_valid;
    logic                        alu_ready;
    regbits_t                    alu_wsel;
    word_t                       alu_wdat;
    logic                        ld_valid;
    logic                        ld_ready;
    regbits_t                    ld_wsel;
    word_t                       ld_wdat;
    logic                        iss_valid;
    regbits_t                    iss_wsel;
    regbits_t                    rsel1;
    regbits_t                    rsel2;
    logic                        rsel1_busy;
    logic                        rsel2_busy;
    logic                        rf_WEN;
    regbits_t                    rf_wsel;
    word_t                       rf_wdat;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (
        output alu_valid, alu_wsel, alu_wdat, ld_valid, ld_wsel, ld_wdat,
               iss_valid, iss_wsel, rsel1, rsel2,
        input  alu_ready, ld_ready, rsel1_busy, rsel2_busy,
               rf_WEN, rf_wsel, rf_wdat, fifo_count
    );

    modport slave (
        input  alu_valid, alu_wsel, alu_wdat, ld_valid, ld_wsel, ld_wdat,
               iss_valid, iss_wsel, rsel1, rsel2,
        output alu_ready, ld_ready, rsel1_busy, rsel2_busy,
               rf_WEN, rf_wsel, rf_wdat, fifo_count
    );
endinterface

// File: rtl/regfile_writeback_fifo.sv
// Load-result buffer: synchronous FIFO of write-back entries with a registered occupancy count.
module wb_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  wb_entry_t              push_data,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Full/empty come from the count so pointer equality is never ambiguous.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/regfile_writeback.sv
// Write-back arbiter: merges ALU results and buffered loads onto the register file write
// port, with load anti-starvation and a pending-write scoreboard for decode hazards.
module regfile_writeback
    import cpu_types_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int STARVE_MAX = WB_STARVE_MAX
) (
    input logic                CLK,
    input logic                RST,
    regfile_writeback_if.slave wb
);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    wb_entry_t                   ld_entry;
    wb_entry_t                   fifo_head;
    wb_entry_t                   sel_entry;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        ld_push;
    logic                        alu_win;
    logic                        fifo_win;
    logic [SW-1:0]               starve_q;
    logic [SW-1:0]               starve_n;
    logic [31:0]                 pend_q;
    logic [31:0]                 pend_n;

    assign wb.ld_ready   = !fifo_full;
    assign wb.alu_ready  = (starve_q != SW'(STARVE_MAX));
    assign wb.fifo_count = fifo_count;
    assign wb.rsel1_busy = pend_q[wb.rsel1];
    assign wb.rsel2_busy = pend_q[wb.rsel2];

    // Loads to r0 are accepted but never occupy a buffer slot.
    assign ld_push  = wb.ld_valid && !fifo_full && (wb.ld_wsel != '0);
    assign ld_entry = '{wsel: wb.ld_wsel, wdat: wb.ld_wdat};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (ld_push),
        .push_data (ld_entry),
        .pop       (fifo_win),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        alu_win   = wb.alu_valid && wb.alu_ready && (wb.alu_wsel != '0);
        fifo_win  = !alu_win && !fifo_empty;
        sel_entry = alu_win ? '{wsel: wb.alu_wsel, wdat: wb.alu_wdat} : fifo_head;

        starve_n = starve_q;
        if (fifo_empty || fifo_win) starve_n = '0;
        else if (alu_win)           starve_n = starve_q + SW'(1);

        // A new issue to the register being retired this cycle keeps it pending.
        pend_n = pend_q;
        if (alu_win || fifo_win)                   pend_n = pend_n & ~reg_bit(sel_entry.wsel);
        if (wb.iss_valid && (wb.iss_wsel != '0))   pend_n = pend_n | reg_bit(wb.iss_wsel);
        pend_n[0] = 1'b0;
    end

    // Stage boundary: selected write onto the register file port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_q   <= '0;
            pend_q     <= '0;
            wb.rf_WEN  <= 1'b0;
            wb.rf_wsel <= '0;
            wb.rf_wdat <= '0;
        end else begin
            starve_q  <= starve_n;
            pend_q    <= pend_n;
            wb.rf_WEN <= alu_win || fifo_win;
            if (alu_win || fifo_win) begin
                wb.rf_wsel <= sel_entry.wsel;
                wb.rf_wdat <= sel_entry.wdat;
            end
        end
    end
endmodule
